uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter that responds to the CPU's load/store data bus. It is a bus responder: the `riscv` core is the initiator and issues `sw`/`lw` to a 16-byte register window. Bytes written to the data register are queued in a small FIFO and shifted out serially as 8N1 frames on `tx`. The block sits beside the RAM in the memory controller's address decode.

## Interface
- `BASE_ADDR`, default 32'h2000_0000: window base; must be 16-byte aligned.
- `DEPTH`, default 4: TX FIFO depth in bytes; must be a power of two, ≥2.
- `CLKS_PER_BIT`, default 16'd104: reset value of the baud divisor.

Ports:
- `clk`  in  1: system clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `addr`  in  32: byte address from the CPU.
- `wdata`  in  32: store data.
- `we`  in  1: store strobe, one cycle per store.
- `re`  in  1: load strobe, one cycle per load.
- `rdata`  out  32: load data, registered.
- `tx`  out  1: serial output; idle high.

## Operation
- Select is `addr[31:4] == BASE_ADDR[31:4]`. Register offset is `addr[3:2]`; `addr[1:0]` is ignored.
- Offset 0x0, TXDATA:
  - Write pushes `wdata[7:0]` into the FIFO.
  - Read returns 0.
- Offset 0x4, STATUS (read):
  - bit0 full: count == DEPTH.
  - bit1 empty: count == 0.
  - bit2 busy: FSM not IDLE.
  - bit3 overflow: sticky.
  - Other bits read 0.
  - Any write to STATUS clears overflow.
- Offset 0x8, DIV: bits [15:0] are the clocks per bit. Reads return the value zero-extended. A value of 0 is treated as 1.
- Offset 0xC: reads 0; writes are ignored. Unselected accesses have no effect and leave `rdata` at 0.
- Push while full (with no pop in the same cycle): the byte is dropped, overflow is set, and the FIFO is unchanged.
- Push and pop in the same cycle: both take effect and the count is unchanged. This holds even when full, and overflow is not set.
- FIFO is a circular buffer with a log2(DEPTH)-bit read and write pointer. Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, latch the divisor, and go to START.
  - START: `tx`=0 for one bit period, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0], LSB first. At the end of each bit period, shift right and increment the index. After index 7, go to STOP.
  - STOP: `tx`=1 for one bit period. Then go to IDLE.
- A bit period is the latched divisor in clocks, counted by a 16-bit down counter. The divisor is re-latched only at the IDLE→START transition, so a DIV write mid-frame affects the next frame only.
- Back-to-back frames: STOP→IDLE→START adds exactly one idle-high cycle between frames.
- `rst` mid-frame: `tx` goes high immediately (asynchronously), the frame is aborted, and the FIFO is flushed.

## Timing
- Reset values:
  - `tx`=1, `rdata`=0.
  - FSM IDLE.
  - FIFO empty, pointers 0.
  - overflow=0.
  - DIV=CLKS_PER_BIT.
- Read latency 1: `rdata` is valid the cycle after `re`, and is 0 the cycle after any non-read or unselected cycle.
- Writes take effect at the edge where `we`=1. The CPU needs no wait state.
- `we` and `re` are never asserted together. If they are, the write happens and `rdata` returns the pre-write value.
- Push at edge N into an empty FIFO while IDLE:
  - IDLE sees non-empty after edge N and pops at edge N+1.
  - `tx` falls at edge N+1.
  - STATUS.empty reads 1 from cycle N+1.
- Frame length is 10×div cycles, from the falling edge of `tx` to the end of STOP.
- STATUS reflects state as of the `re` edge.

## Test plan
- Reset, then read STATUS → 0x2. Read DIV → 104. `tx`=1.
- DIV=4, write TXDATA=0xA5 → `tx` falls one cycle later. Sampling every 4 clocks gives 0,1,0,1,0,0,1,0,1,1, i.e. start, LSB-first 0xA5, stop. busy=1 during the frame and 0 after 40+1 cycles.
- DIV=2, write 0x01 then 0xFF, 0x00, 0x55, 0x80 back-to-back:
  - The first byte is popped immediately, so all 4 queued bytes fit and full=1.
  - A sixth write sets overflow=1.
  - Frames go out in order with 1 idle cycle between them.
  - A write to STATUS clears overflow.
- Write DIV=8 mid-frame with DIV=2 → the current frame keeps 2-clock bits and the next frame uses 8.
- Assert `rst` during DATA of a frame with 3 bytes queued → `tx`=1 immediately. After release, STATUS=0x2 and no further frames are sent.
- Read of offset 0xC and of address BASE_ADDR+0x10 → `rdata`=0. Write to both → no state change and no transmission.

Source files
------------

// File: rtl/uart_tx_mmio_if.sv
// CPU load/store data bus as seen by a memory-mapped responder.
// The core drives address, data and strobes; the responder returns rdata.
interface uart_tx_mmio_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;

  modport master (
    output addr,
    output wdata,
    output we,
    output re,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  we,
    input  re,
    output rdata
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIV registers,
// a small byte FIFO and a start/data/stop shift FSM.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h2000_0000,
  parameter int          DEPTH        = 4,
  parameter logic [15:0] CLKS_PER_BIT = 16'd104
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_mmio_if.slave   bus,
  output logic            tx
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state;
  state_t nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          ovf;
  logic [15:0]   div;
  logic [15:0]   bdiv;
  logic [15:0]   cnt;
  logic [7:0]    shreg;
  logic [2:0]    idx;

  logic        sel;
  logic [1:0]  off;
  logic        wr;
  logic        rd;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        busy;
  logic        do_push;
  logic        tick;
  logic [15:0] div_eff;
  logic        unused;

  assign sel     = bus.addr[31:4] == BASE_ADDR[31:4];
  assign off     = bus.addr[3:2];
  assign wr      = bus.we & sel;
  assign rd      = bus.re & sel;
  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign busy    = state != IDLE;
  assign push    = wr & (off == 2'd0);
  assign pop     = (state == IDLE) & ~empty;
  // A simultaneous pop frees a slot, so a push while full still lands.
  assign do_push = push & (~full | pop);
  assign tick    = cnt == 16'd0;
  assign div_eff = (div == 16'd0) ? 16'd1 : div;
  assign unused  = ^{bus.addr[1:0], bus.wdata[31:16], BASE_ADDR[3:0]};

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      unique case ({do_push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      div <= CLKS_PER_BIT;
    end else begin
      if (wr && off == 2'd1)          ovf <= 1'b0;
      else if (push && full && !pop)  ovf <= 1'b1;
      if (wr && off == 2'd2)          div <= bus.wdata[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rdata <= '0;
    end else if (rd) begin
      unique case (off)
        2'd1:    bus.rdata <= {28'd0, ovf, busy, empty, full};
        2'd2:    bus.rdata <= {16'd0, div};
        default: bus.rdata <= '0;
      endcase
    end else begin
      bus.rdata <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (!empty) nxt = START;
      START: if (tick) nxt = DATA;
      DATA:  if (tick && idx == 3'd7) nxt = STOP;
      STOP:  if (tick) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    unique case (state)
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      default: tx = 1'b1;
    endcase
  end

  // Divisor is captured only when a frame starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      idx   <= '0;
      cnt   <= '0;
      bdiv  <= 16'd1;
    end else if (state == IDLE) begin
      if (pop) begin
        shreg <= mem[rptr];
        bdiv  <= div_eff;
        cnt   <= div_eff - 16'd1;
        idx   <= '0;
      end
    end else if (tick) begin
      cnt <= bdiv - 16'd1;
      if (state == DATA) begin
        shreg <= {1'b0, shreg[7:1]};
        idx   <= idx + 3'd1;
      end
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: register access, framing, FIFO overflow,
// divisor latching, reset abort and address decode.
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  int   errors = 0;
  int   checks = 0;

  uart_tx_mmio_if bus();

  uart_tx_mmio #(
    .BASE_ADDR   (BASE),
    .DEPTH       (DEPTH),
    .CLKS_PER_BIT(16'd104)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .tx (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    @(negedge clk);
    bus.we    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    bus.re   = 1'b1;
    @(negedge clk);
    bus.re   = 1'b0;
    d        = bus.rdata;
  endtask

  // Serial receiver: waits for a start bit, then samples every clock
  // of all ten bit periods; gap = idle-high samples seen before start.
  task automatic capture(input int div, input int budget,
                         output logic [7:0] data, output bit ok,
                         output int gap);
    logic first;
    bit   seen;
    data = 'x;
    ok   = 1'b1;
    gap  = 0;
    seen = 1'b0;
    first = 1'b1;
    while (!seen) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1'b1;
      else begin
        gap++;
        if (gap >= budget) begin
          gap = -1;
          ok  = 1'b0;
          return;
        end
      end
    end
    for (int b = 0; b < 10; b++)
      for (int s = 0; s < div; s++) begin
        if (b != 0 || s != 0) @(negedge clk);
        if (s == 0) first = tx;
        else if (tx !== first) ok = 1'b0;
        if (b == 0 && tx !== 1'b0) ok = 1'b0;
        if (b == 9 && tx !== 1'b1) ok = 1'b0;
        if (b >= 1 && b <= 8) data[b-1] = first;
      end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.we    = 1'b0;
    bus.re    = 1'b0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      errors++; $display("FAIL reset_tx got %b want 1", tx);
    end
    checks++;
    if (bus.rdata !== 32'd0) begin
      errors++; $display("FAIL reset_rdata got %h want 0", bus.rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL reset_status got %h want 2", d);
    end
    bus_read(BASE + 32'h8, d);
    checks++;
    if (d !== 32'd104) begin
      errors++; $display("FAIL reset_div got %0d want 104", d);
    end
  endtask

  task automatic test_single;
    logic [31:0] d;
    logic [7:0]  b;
    bit          ok;
    int          g;
    bus_write(BASE + 32'h8, 32'd4);
    bus_write(BASE, 32'hA5);
    checks++;
    if (tx !== 1'b1) begin
      errors++; $display("FAIL single_early got tx=%b want 1", tx);
    end
    capture(4, 20, b, ok, g);
    checks++;
    if (g != 0) begin
      errors++; $display("FAIL single_latency got gap=%0d want 0", g);
    end
    checks++;
    if (!ok || b !== 8'hA5) begin
      errors++; $display("FAIL single_frame got %h ok=%0d want a5 ok=1", b, ok);
    end
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h6) begin
      errors++; $display("FAIL single_busy_stop got %h want 6", d);
    end
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL single_idle got %h want 2", d);
    end
  endtask

  task automatic test_status_busy;
    logic [31:0] d;
    bus_write(BASE + 32'h8, 32'd3);
    bus_write(BASE, 32'h3C);
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL status_queued got %h want 0", d);
    end
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h6) begin
      errors++; $display("FAIL status_busy got %h want 6", d);
    end
    repeat (40) @(negedge clk);
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL status_done got %h want 2", d);
    end
  endtask

  task automatic test_overflow;
    logic [7:0]  exp_b [5];
    logic [31:0] d;
    logic [7:0]  b;
    bit          ok;
    int          g;
    exp_b = '{8'h01, 8'hFF, 8'h00, 8'h55, 8'h80};
    bus_write(BASE + 32'h8, 32'd2);
    fork
      begin
        logic [31:0] s;
        for (int i = 0; i < 5; i++) bus_write(BASE, {24'd0, exp_b[i]});
        bus_read(BASE + 32'h4, s);
        checks++;
        if (s !== 32'h5) begin
          errors++; $display("FAIL ovf_full got %h want 5", s);
        end
        bus_write(BASE, 32'h77);
        bus_read(BASE + 32'h4, s);
        checks++;
        if (s !== 32'hD) begin
          errors++; $display("FAIL ovf_set got %h want d", s);
        end
        bus_write(BASE + 32'h4, 32'h0);
        bus_read(BASE + 32'h4, s);
        checks++;
        if (s !== 32'h5) begin
          errors++; $display("FAIL ovf_clear got %h want 5", s);
        end
      end
      begin
        logic [7:0] rb;
        bit         rok;
        int         rg;
        for (int k = 0; k < 5; k++) begin
          capture(2, 60, rb, rok, rg);
          checks++;
          if (!rok || rb !== exp_b[k] || rg != 1) begin
            errors++;
            $display("FAIL ovf_frame%0d got %h ok=%0d gap=%0d want %h ok=1 gap=1",
                     k, rb, rok, rg, exp_b[k]);
          end
        end
      end
    join
    capture(2, 30, b, ok, g);
    checks++;
    if (g != -1) begin
      errors++; $display("FAIL ovf_extra got gap=%0d byte=%h want none", g, b);
    end
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL ovf_final got %h want 2", d);
    end
  endtask

  task automatic test_div_mid;
    logic [31:0] d;
    logic [7:0]  b;
    bit          ok;
    int          g;
    bus_write(BASE + 32'h8, 32'd2);
    fork
      begin
        bus_write(BASE, 32'h3A);
        bus_write(BASE, 32'hC5);
        repeat (6) @(negedge clk);
        bus_write(BASE + 32'h8, 32'd8);
      end
      begin
        capture(2, 20, b, ok, g);
        checks++;
        if (!ok || b !== 8'h3A || g != 1) begin
          errors++;
          $display("FAIL divmid_first got %h ok=%0d gap=%0d want 3a ok=1 gap=1", b, ok, g);
        end
        capture(8, 20, b, ok, g);
        checks++;
        if (!ok || b !== 8'hC5 || g != 1) begin
          errors++;
          $display("FAIL divmid_second got %h ok=%0d gap=%0d want c5 ok=1 gap=1", b, ok, g);
        end
      end
    join
    bus_read(BASE + 32'h8, d);
    checks++;
    if (d !== 32'd8) begin
      errors++; $display("FAIL divmid_read got %0d want 8", d);
    end
  endtask

  task automatic test_random;
    logic [15:0] draw;
    int          de;
    int          w;
    int          acc;
    logic [31:0] words [7];
    logic [7:0]  q [$];
    logic [31:0] d;
    logic [7:0]  b;
    bit          ok;
    int          g;
    for (int it = 0; it < 4; it++) begin
      draw = 16'($urandom_range(0, 3));
      de   = (draw == 16'd0) ? 1 : int'(draw);
      w    = $urandom_range(1, 7);
      acc  = (w > DEPTH + 1) ? DEPTH + 1 : w;
      q.delete();
      for (int i = 0; i < 7; i++) begin
        words[i] = $urandom;
        if (i < acc) q.push_back(words[i][7:0]);
      end
      bus_write(BASE + 32'h8 + 32'($urandom_range(0, 3)), {16'hBEEF, draw});
      bus_read(BASE + 32'h8, d);
      checks++;
      if (d !== {16'd0, draw}) begin
        errors++; $display("FAIL rand%0d_div got %h want %h", it, d, draw);
      end
      fork
        begin
          for (int i = 0; i < w; i++)
            bus_write(BASE + 32'($urandom_range(0, 3)), words[i]);
        end
        begin
          logic [7:0] rb;
          bit         rok;
          int         rg;
          for (int k = 0; k < acc; k++) begin
            capture(de, 10 * de + 20, rb, rok, rg);
            checks++;
            if (!rok || rb !== q[k] || rg != 1) begin
              errors++;
              $display("FAIL rand%0d_frame%0d got %h ok=%0d gap=%0d want %h ok=1 gap=1",
                       it, k, rb, rok, rg, q[k]);
            end
          end
        end
      join
      capture(de, 10 * de + 5, b, ok, g);
      checks++;
      if (g != -1) begin
        errors++; $display("FAIL rand%0d_extra got gap=%0d want none", it, g);
      end
      bus_read(BASE + 32'h4, d);
      checks++;
      if (d !== ((w > acc) ? 32'hA : 32'h2)) begin
        errors++;
        $display("FAIL rand%0d_status got %h want %h", it, d, (w > acc) ? 32'hA : 32'h2);
      end
      bus_write(BASE + 32'h4, 32'hFFFF_FFFF);
      bus_read(BASE + 32'h4, d);
      checks++;
      if (d !== 32'h2) begin
        errors++; $display("FAIL rand%0d_clear got %h want 2", it, d);
      end
    end
  endtask

  task automatic test_unselected;
    logic [31:0] d;
    logic [7:0]  b;
    bit          ok;
    int          g;
    bus_write(BASE + 32'h8, 32'd3);
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL unsel_status got %h want 2", d);
    end
    @(negedge clk);
    checks++;
    if (bus.rdata !== 32'd0) begin
      errors++; $display("FAIL unsel_idle_rdata got %h want 0", bus.rdata);
    end
    bus_read(BASE + 32'h8, d);
    bus_read(BASE + 32'hC, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL unsel_off_c got %h want 0", d);
    end
    bus_read(BASE + 32'h8, d);
    bus_read(BASE + 32'h18, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL unsel_outside got %h want 0", d);
    end
    bus_read(BASE, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL unsel_txdata_read got %h want 0", d);
    end
    bus_write(BASE + 32'hC, 32'hFF);
    bus_write(BASE + 32'h10, 32'h55);
    bus_write(BASE + 32'h18, 32'd9);
    capture(3, 40, b, ok, g);
    checks++;
    if (g != -1) begin
      errors++; $display("FAIL unsel_no_tx got gap=%0d byte=%h want none", g, b);
    end
    bus_read(BASE + 32'h8, d);
    checks++;
    if (d !== 32'd3) begin
      errors++; $display("FAIL unsel_div got %0d want 3", d);
    end
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL unsel_status_after got %h want 2", d);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic [7:0]  b;
    bit          ok;
    int          g;
    bus_write(BASE + 32'h8, 32'd2);
    for (int i = 0; i < 4; i++) bus_write(BASE, 32'h00);
    repeat (2) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      errors++; $display("FAIL rstmid_data_low got %b want 0", tx);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin
      errors++; $display("FAIL rstmid_async_tx got %b want 1", tx);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_read(BASE + 32'h4, d);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL rstmid_status got %h want 2", d);
    end
    capture(104, 300, b, ok, g);
    checks++;
    if (g != -1) begin
      errors++; $display("FAIL rstmid_no_tx got gap=%0d byte=%h want none", g, b);
    end
    bus_read(BASE + 32'h8, d);
    checks++;
    if (d !== 32'd104) begin
      errors++; $display("FAIL rstmid_div got %0d want 104", d);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_status_busy();
    test_overflow();
    test_div_mid();
    test_random();
    test_unselected();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
